// File: rtl/imem_loader_if.sv
// Byte-stream load link and instruction fetch port of imem_loader.
// The host/debug side uses the master modport, the loader the slave modport.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] addr;
  logic [31:0] instr;

  modport master (output byte_in, byte_valid, addr, input byte_ready, instr);
  modport slave  (input byte_in, byte_valid, addr, output byte_ready, instr);
endinterface

// File: rtl/imem_loader.sv
// Writable DEPTH x 32 instruction memory loaded from a little-endian byte stream.
// Define IMEM_LOADER_CHECKSUM_EN to add the 4-byte XOR trailer check (CHECK state, chk_err).
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [6:0]   num_words,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic [6:0]   word_count,
  output logic         len_err,
  output logic         chk_err
);
  // state | meaning
  // IDLE  | after reset, core held, waiting for start
  // LOAD  | accepting program bytes, writing one word per 4 bytes
  // CHECK | accepting the 4-byte XOR trailer (checksum build only)
  // DONE  | load finished, core released unless the checksum failed

  localparam int AW = $clog2(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
  localparam state_t S_POST = S_CHECK;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  localparam state_t S_POST = S_DONE;
`endif

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        hold_d, done_d;
  logic [1:0]  lane_q;
  logic [23:0] asm_q;
  logic [6:0]  count_q, count_start;
  logic        over_len, start_ok, xfer, word_wr, last_word;
  logic [31:0] word_full;
  logic [31:0] mem [DEPTH];
  logic        unused_addr_bits;

  assign over_len    = 32'(num_words) > DEPTH;
  assign count_start = over_len ? 7'(DEPTH) : num_words;
  assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign xfer        = bus.byte_valid && ready_q;
  assign word_full   = {bus.byte_in, asm_q};
  assign word_wr     = xfer && (state_q == S_LOAD) && (lane_q == 2'd3);
  assign last_word   = word_wr && ((word_count + 7'd1) == count_q);

  assign bus.byte_ready   = ready_q;
  assign bus.instr        = mem[bus.addr[AW+1:2]];
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        chk_last, chk_err_d;

  assign chk_last = xfer && (state_q == S_CHECK) && (lane_q == 2'd3);
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_err  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cpu_hold <= hold_d;
      done     <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_err  <= chk_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (count_start == 7'd0) ? S_POST : S_LOAD;
      end
      S_LOAD: begin
        if (last_word) state_d = S_POST;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (chk_last) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops together with it.
  always_comb begin
    done_d = (state_d == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d   = (state_d == S_LOAD) || (state_d == S_CHECK);
    chk_err_d = chk_err;
    if (start_ok)      chk_err_d = 1'b0;
    else if (chk_last) chk_err_d = (word_full != csum_q);
    hold_d = !done_d || chk_err_d;
`else
    ready_d = (state_d == S_LOAD);
    hold_d  = !done_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= 7'd0;
      lane_q     <= 2'd0;
      asm_q      <= 24'd0;
      count_q    <= 7'd0;
      len_err    <= 1'b0;
    end else if (start_ok) begin
      word_count <= 7'd0;
      lane_q     <= 2'd0;
      asm_q      <= 24'd0;
      count_q    <= count_start;
      len_err    <= over_len;
    end else if (xfer) begin
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0:    asm_q[7:0]   <= bus.byte_in;
        2'd1:    asm_q[15:8]  <= bus.byte_in;
        2'd2:    asm_q[23:16] <= bus.byte_in;
        default: asm_q        <= asm_q;
      endcase
      if (word_wr) word_count <= word_count + 7'd1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      csum_q <= 32'd0;
    else if (start_ok) csum_q <= 32'd0;
    else if (word_wr)  csum_q <= csum_q ^ word_full;
  end
`endif

  // Storage is deliberately not reset so a reset mid-load keeps already written words.
  always_ff @(posedge clk) begin
    if (word_wr) mem[word_count[AW-1:0]] <= word_full;
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, hand-written corner
// sequences and randomized loads checked against an array model of the memory.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] num_words = 7'd0;
  logic       cpu_hold, done, len_err, chk_err;
  logic [6:0] word_count;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
    .bus(bus), .cpu_hold(cpu_hold), .done(done), .word_count(word_count),
    .len_err(len_err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [DEPTH];
  bit          exp_vld [DEPTH];

  typedef struct {
    int nw;
    int gap;
    bit exp_len_err;
    int exp_wc;
  } load_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
  } fetch_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.instr, exp);
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_vld[i]) begin
        a = $urandom;
        a[7:2] = 6'(i);
        check_fetch($sformatf("%s mem[%0d]", tag, i), a, exp_mem[i]);
      end
    end
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, inout int cyc);
    bit acc;
    bit ok = 1'b0;
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!ok && n < 50) begin
      acc = bus.byte_ready;
      tick();
      n++;
      cyc++;
      if (acc) ok = 1'b1;
    end
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept: byte 0x%02h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic load_stream(input logic [7:0] bytes[$], input int gap_mode, output int cyc);
    cyc = 0;
    foreach (bytes[i]) begin
      if (gap_mode == 1 && i > 0) repeat ($urandom_range(0, 2)) tick();
      if (gap_mode == 2 && i > 0) repeat (2) tick();
      send_byte(bytes[i], cyc);
      if (i == bytes.size() - 2) check("done_before_last_byte", done, 1'b0);
    end
  endtask

  task automatic build_stream(input logic [31:0] words[$], input int n, input bit bad,
                              output logic [7:0] bytes[$]);
    logic [31:0] x = 32'd0;
    logic [31:0] wv;
    bytes = {};
    for (int w = 0; w < n; w++) begin
      wv = words[w];
      for (int b = 0; b < 4; b++) bytes.push_back(wv[8*b +: 8]);
      x ^= wv;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (bad) x = 32'd0;
    for (int b = 0; b < 4; b++) bytes.push_back(x[8*b +: 8]);
`else
    if (bad) x = 32'd0;
`endif
  endtask

  task automatic start_load(input logic [6:0] nw);
    start     = 1'b1;
    num_words = nw;
    tick();
    start     = 1'b0;
    num_words = 7'($urandom);
  endtask

  task automatic finish_checks(input string tag, input int exp_wc, input bit exp_len, input bit bad);
    bit exp_chk;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_chk = bad;
`else
    exp_chk = 1'b0;
    if (bad) exp_chk = 1'b0;
`endif
    check({tag, " done"}, done, 1'b1);
    check({tag, " word_count"}, word_count, exp_wc);
    check({tag, " len_err"}, len_err, exp_len);
    check({tag, " chk_err"}, chk_err, exp_chk);
    check({tag, " cpu_hold"}, cpu_hold, exp_chk);
    check({tag, " ready_in_done"}, bus.byte_ready, 1'b0);
  endtask

  task automatic run_load(input string tag, input int nw, input logic [31:0] words[$],
                          input int gap_mode, input bit bad, input int exp_wc, input bit exp_len);
    logic [7:0] bytes[$];
    int cyc;
    build_stream(words, exp_wc, bad, bytes);
    start_load(7'(nw));
    check({tag, " ready_after_start"}, bus.byte_ready, bytes.size() != 0);
    check({tag, " done_after_start"}, done, bytes.size() == 0);
    check({tag, " hold_after_start"}, cpu_hold, bytes.size() != 0);
    check({tag, " len_err_at_start"}, len_err, exp_len);
    check({tag, " chk_err_cleared"}, chk_err, 1'b0);
    load_stream(bytes, gap_mode, cyc);
    if (gap_mode == 0) check({tag, " cycles"}, cyc, bytes.size());
    finish_checks(tag, exp_wc, exp_len, bad);
    for (int w = 0; w < exp_wc; w++) begin
      exp_mem[w] = words[w];
      exp_vld[w] = 1'b1;
    end
    check_mem(tag);
  endtask

  task automatic rand_words(input int n, output logic [31:0] words[$]);
    words = {};
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_vec_t   vecs[$];
    fetch_vec_t  fv[$];
    logic [31:0] wq[$];
    logic [7:0]  bq[$];
    logic [31:0] old1, new0;
    int          cyc, nw, ewc;

    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    bus.addr       = 32'd0;
    for (int i = 0; i < DEPTH; i++) exp_vld[i] = 1'b0;

    vecs = '{
      '{nw: 2,   gap: 2, exp_len_err: 1'b0, exp_wc: 2},
      '{nw: 0,   gap: 0, exp_len_err: 1'b0, exp_wc: 0},
      '{nw: 1,   gap: 1, exp_len_err: 1'b0, exp_wc: 1},
      '{nw: 100, gap: 0, exp_len_err: 1'b1, exp_wc: 64},
      '{nw: 64,  gap: 1, exp_len_err: 1'b0, exp_wc: 64},
      '{nw: 65,  gap: 0, exp_len_err: 1'b1, exp_wc: 64},
      '{nw: 127, gap: 0, exp_len_err: 1'b1, exp_wc: 64},
      '{nw: 63,  gap: 0, exp_len_err: 1'b0, exp_wc: 63}
    };

    repeat (3) tick();
    check("reset done", done, 1'b0);
    check("reset cpu_hold", cpu_hold, 1'b1);
    check("reset byte_ready", bus.byte_ready, 1'b0);
    check("reset word_count", word_count, 7'd0);
    check("reset len_err", len_err, 1'b0);
    check("reset chk_err", chk_err, 1'b0);
    reset_n = 1'b1;
    tick();
    bus.byte_valid = 1'b1;
    tick();
    check("idle ignores bytes", bus.byte_ready, 1'b0);
    bus.byte_valid = 1'b0;

    // Basic load with the reference program, then fetch index decoding.
    wq = '{32'h0000_0013, 32'h0010_0093};
    run_load("basic", 2, wq, 0, 1'b0, 2, 1'b0);
    fv = '{
      '{addr: 32'h0000_0000, exp_instr: 32'h0000_0013},
      '{addr: 32'h0000_0004, exp_instr: 32'h0010_0093},
      '{addr: 32'h0000_0104, exp_instr: 32'h0010_0093},
      '{addr: 32'h0000_0007, exp_instr: 32'h0010_0093},
      '{addr: 32'h0000_0102, exp_instr: 32'h0000_0013},
      '{addr: 32'hFFFF_FF06, exp_instr: 32'h0010_0093}
    };
    foreach (fv[i]) check_fetch($sformatf("fetch[%0d]", i), fv[i].addr, fv[i].exp_instr);
    tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load("csum_bad", 2, wq, 0, 1'b1, 2, 1'b0);
    run_load("csum_ok", 2, wq, 0, 1'b0, 2, 1'b0);
`endif

    foreach (vecs[i]) begin
      rand_words(vecs[i].exp_wc, wq);
      run_load($sformatf("vec%0d", i), vecs[i].nw, wq, vecs[i].gap, 1'b0,
               vecs[i].exp_wc, vecs[i].exp_len_err);
    end

    // Reset after 5 bytes of a 3-word load: word 0 is kept, word 1 untouched.
    old1 = exp_mem[1];
    rand_words(3, wq);
    build_stream(wq, 3, 1'b0, bq);
    start_load(7'd3);
    cyc = 0;
    for (int i = 0; i < 5; i++) send_byte(bq[i], cyc);
    check("midreset word_count_before", word_count, 7'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset cpu_hold", cpu_hold, 1'b1);
    check("midreset done", done, 1'b0);
    check("midreset byte_ready", bus.byte_ready, 1'b0);
    check("midreset word_count", word_count, 7'd0);
    new0 = wq[0];
    exp_mem[0] = new0;
    check_fetch("midreset mem0", 32'h0, new0);
    check_fetch("midreset mem1", 32'h4, old1);
    tick();
    reset_n = 1'b1;
    tick();

    // Reload from DONE after a fresh start, 1 word.
    rand_words(1, wq);
    run_load("after_reset", 1, wq, 0, 1'b0, 1, 1'b0);
    rand_words(1, wq);
    run_load("reload", 1, wq, 0, 1'b0, 1, 1'b0);

    // start during LOAD must not restart or re-latch the count.
    rand_words(2, wq);
    build_stream(wq, 2, 1'b0, bq);
    start_load(7'd2);
    cyc = 0;
    for (int i = 0; i < 3; i++) send_byte(bq[i], cyc);
    start     = 1'b1;
    num_words = 7'd0;
    tick();
    start = 1'b0;
    check("start_in_load ready", bus.byte_ready, 1'b1);
    check("start_in_load done", done, 1'b0);
    load_stream(bq[3:$], 0, cyc);
    finish_checks("start_in_load", 2, 1'b0, 1'b0);
    exp_mem[0] = wq[0];
    exp_mem[1] = wq[1];
    check_mem("start_in_load");

    for (int it = 0; it < 6; it++) begin
      nw  = $urandom_range(0, 80);
      ewc = (nw > DEPTH) ? DEPTH : nw;
      rand_words(ewc, wq);
      run_load($sformatf("rand%0d", it), nw, wq, $urandom_range(0, 1), 1'b0, ewc, nw > DEPTH);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream program loader: accepts a program as a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them into a 64 x 32 memory. The processor fetch path reads the memory combinationally, word-aligned, exactly as it reads the ROM-style instruction memory. It sits between the host/debug byte link and the processor's instruction fetch port, and holds the core via `cpu_hold` until a load completes.

## Interface
- `DEPTH`, 64: words of storage; power of two; address index is `addr[$clog2(DEPTH)+1:2]`.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a load; sampled in IDLE or DONE.
- `num_words`  input  7  words to load, latched when `start` is accepted.
- `byte_in`  input  8  program byte, LSB of each word first.
- `byte_valid`  input  1  `byte_in` is valid.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `addr`  input  32  fetch byte address; bits [1:0] and bits above the index are ignored.
- `instr`  output  32  fetched word, combinational.
- `cpu_hold`  output  1  keep the processor stalled or in reset.
- `done`  output  1  load complete.
- `word_count`  output  7  words written in the current load.
- `len_err`  output  1  `num_words` exceeded DEPTH and was clamped.
- `chk_err`  output  1  checksum mismatch; tied 0 when the feature is out.

## Operation
- States: IDLE, LOAD, CHECK (feature only), DONE.
- Reset values: state IDLE, `byte_ready`=0, `cpu_hold`=1, `done`=0, `word_count`=0, `len_err`=0, `chk_err`=0. Byte lane counter and assembly register are 0. Memory contents are not reset.
- IDLE, `start`=1 -> LOAD. The loader latches `min(num_words, DEPTH)` and sets `len_err` if `num_words` > DEPTH. It clears `word_count`, the lane counter, `len_err` from any earlier load, and `chk_err`.
- If the latched count is 0, the loader goes to DONE (or CHECK) instead of LOAD, and makes no writes.
- LOAD: `byte_ready`=1. A transfer is `byte_valid && byte_ready`. Lane n (0..3) fills bits [8n+7:8n].
- On the lane-3 transfer, the assembled word is written to `memory[word_count]` and `word_count` increments. Lane wraps to 0.
- When `word_count` reaches the latched count: -> DONE, or -> CHECK when the feature is in.
- DONE: `done`=1, `cpu_hold`=0, `byte_ready`=0. `start` restarts the load; the state becomes LOAD and `done` and `cpu_hold` return to 0 and 1.
- `start` in LOAD or CHECK is ignored. Bytes offered outside LOAD or CHECK are not accepted.
- `instr` = `memory[addr index]` at all times, including during a load. A word being written returns its old value until the write edge.
- `reset_n` low mid-load: immediate return to IDLE and reset values. A partially assembled word is discarded. Words already written remain.

## Timing
- `start` sampled at edge k: `byte_ready`=1 from cycle k+1.
- Lane-3 byte accepted at edge k: the word is visible on `instr` after edge k, and `word_count` updates at edge k.
- The last word is written at edge k: DONE, `done`=1, `cpu_hold`=0 after edge k.
- Full rate: N words take 4N cycles from the first byte. Gaps in `byte_valid` stall the load without losing lane state.
- All outputs except `instr` are registered.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running XOR of every written word is kept; it is cleared at `start`.
  - After the last word, CHECK accepts 4 more bytes as the expected XOR. These bytes are not written to memory.
  - On a mismatch, `chk_err`=1. Then -> DONE in both cases.
  - `cpu_hold` stays 1 in DONE while `chk_err`=1.
- Not defined: no CHECK state, no trailer bytes, `chk_err` tied 0.

## Test plan
- Basic load: `num_words`=2, bytes 13 00 00 00 93 00 10 00 at full rate -> `memory[0]`=0x00000013 and `memory[1]`=0x00100093. `done` is high 8 cycles after the first byte. `addr`=0x4 reads 0x00100093, and `addr`=0x104 reads the same word (index wrap).
- Backpressure gaps: same stream with `byte_valid` toggled 1,0,0,1... -> identical memory, `word_count`=2, no byte dropped or duplicated.
- Zero and over-length: `num_words`=0 -> DONE next cycle with `word_count`=0 and no writes. `num_words`=100 -> `len_err`=1, and DONE after 64 words (256 bytes).
- Reset mid-load: `reset_n` low after 5 bytes of a 3-word load -> `memory[0]` keeps the new word, `memory[1]` is unchanged, state IDLE, `cpu_hold`=1.
- Reload: `start` in DONE with a new 1-word stream -> `done` drops for the load and `memory[0]` is updated.
- Checksum (macro on): words 0x00000013 and 0x00100093 with trailer 80 00 10 00 -> `chk_err`=0 and `cpu_hold`=0. Trailer 00 00 00 00 -> `chk_err`=1 and `cpu_hold` stays 1.
